// File: rtl/uart_rx_cfg_if.sv
// Serial-side and word-side signals of the configurable UART receiver.
// master drives the line, tick and run-time config; slave is the receiver.
interface uart_rx_cfg_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            parity_en;
  logic            parity_odd;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            parity_err;
  logic            frame_err;

  modport master (
    output rx, s_tick, parity_en, parity_odd,
    input  dout, rx_done_tick, parity_err, frame_err
  );

  modport slave (
    input  rx, s_tick, parity_en, parity_odd,
    output dout, rx_done_tick, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: DBIT data bits, optional run-time parity, SB_TICK stop ticks.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting of data/parity/stop bits.
module uart_rx_cfg #(
  parameter int DBIT    = 8,
  parameter int OSR     = 16,
  parameter int SB_TICK = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_cfg_if.slave  bus
);
  localparam int SMAX = (OSR > SB_TICK) ? OSR : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT) + 1;

  localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            pen_q, pen_d;
  logic            podd_q, podd_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            rx_s;
  logic            bit_val;

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // hist_q[1] = sample at tick OSR-3, hist_q[0] = tick OSR-2; rx_s supplies tick OSR-1
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (bus.s_tick && (state_q == DATA || state_q == PARITY || state_q == STOP))
      hist_d = {hist_q[0], rx_s};
    bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 2'b11;
    else       hist_q <= hist_d;
  end
`else
  always_comb bit_val = rx_s;
`endif

  always_comb begin
    sync_d       = {sync_q[0], bus.rx};
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    pen_d        = pen_q;
    podd_d       = podd_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        pen_d  = bus.parity_en;
        podd_d = bus.parity_odd;
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: if (bus.s_tick) begin
        if (s_q == S_HALF) begin
          if (!rx_s) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      DATA: if (bus.s_tick) begin
        if (s_q == S_LAST) begin
          b_d = {bit_val, b_q[DBIT-1:1]};
          s_d = '0;
          if (n_q == N_LAST) state_d = pen_q ? PARITY : STOP;
          else               n_d     = n_q + 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      PARITY: if (bus.s_tick) begin
        if (s_q == S_LAST) begin
          perr_d  = (^b_q) ^ bit_val ^ podd_q;
          s_d     = '0;
          state_d = STOP;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      STOP: if (bus.s_tick) begin
        if (s_q == S_LAST) ferr_d = ~bit_val;
        if (s_q == S_STOP) begin
          // with SB_TICK == OSR the stop sample and frame end share a tick
          state_d      = IDLE;
          parity_err_d = pen_q & perr_q;
          frame_err_d  = (s_q == S_LAST) ? ~bit_val : ferr_q;
          done_d       = 1'b1;
        end else begin
          s_d = s_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      pen_q        <= 1'b0;
      podd_q       <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      pen_q        <= pen_d;
      podd_q       <= podd_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.dout         = b_q;
  assign bus.rx_done_tick = done_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg (DBIT=8, OSR=16, SB_TICK=16, s_tick every 4 clk).
// Majority-vote expectation follows UART_RX_MAJORITY_EN.
module tb_uart_rx_cfg;
  localparam int OSR = 16;
  localparam int NONE = -1;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   long_pulse = 0;
  logic prev_done = 1'b0;
  int   exp_done;

  uart_rx_cfg_if #(.DBIT(8)) bus();

  uart_rx_cfg #(.DBIT(8), .OSR(OSR), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.rx_done_tick) begin
        done_cnt <= done_cnt + 1;
        if (prev_done) long_pulse <= long_pulse + 1;
      end
      prev_done <= bus.rx_done_tick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one oversampling period: rx settles through the synchroniser before the strobe
  task automatic do_tick();
    repeat (3) @(negedge clk);
    bus.s_tick = 1'b1;
    @(negedge clk);
    bus.s_tick = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit with_par, input logic par_bit,
                            input bit stop_low, input int glitch_t, input int stop_at,
                            input int flip_t);
    logic [15:0] fb;
    int nb;
    logic rx_v;
    fb = '0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[1+i] = data[i];
    nb = 9;
    if (with_par) begin
      fb[nb] = par_bit;
      nb++;
    end
    fb[nb] = 1'b1;
    nb++;
    for (int t = 0; t < nb * OSR; t++) begin
      if (t == stop_at) return;
      if (t == flip_t) bus.parity_en = ~bus.parity_en;
      rx_v = fb[t / OSR];
      if (stop_low && (t / OSR == nb - 1) && (t % OSR < OSR / 2)) rx_v = 1'b0;
      if (t == glitch_t) rx_v = 1'b1;
      bus.rx = rx_v;
      do_tick();
    end
    bus.rx = 1'b1;
    repeat (2 * OSR) do_tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.rx = 1'b1;
    bus.s_tick = 1'b0;
    bus.parity_en = 1'b0;
    bus.parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'h0);
    chk("rst_done", 32'(bus.rx_done_tick), 32'h0);
    chk("rst_perr", 32'(bus.parity_err), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_done = 0;

    send_frame(8'hA5, 0, 1'b0, 0, NONE, NONE, NONE);
    exp_done++;
    chk("a5_done", 32'(done_cnt), 32'(exp_done));
    chk("a5_dout", 32'(bus.dout), 32'hA5);
    chk("a5_perr", 32'(bus.parity_err), 32'h0);
    chk("a5_ferr", 32'(bus.frame_err), 32'h0);

    bus.parity_en = 1'b1;
    send_frame(8'h03, 1, 1'b0, 0, NONE, NONE, NONE);
    exp_done++;
    chk("even_ok_done", 32'(done_cnt), 32'(exp_done));
    chk("even_ok_dout", 32'(bus.dout), 32'h03);
    chk("even_ok_perr", 32'(bus.parity_err), 32'h0);

    send_frame(8'h03, 1, 1'b1, 0, NONE, NONE, NONE);
    exp_done++;
    chk("even_bad_done", 32'(done_cnt), 32'(exp_done));
    chk("even_bad_dout", 32'(bus.dout), 32'h03);
    chk("even_bad_perr", 32'(bus.parity_err), 32'h1);

    bus.parity_odd = 1'b1;
    send_frame(8'h07, 1, 1'b0, 0, NONE, NONE, NONE);
    exp_done++;
    chk("odd_ok_done", 32'(done_cnt), 32'(exp_done));
    chk("odd_ok_dout", 32'(bus.dout), 32'h07);
    chk("odd_ok_perr", 32'(bus.parity_err), 32'h0);
    send_frame(8'h07, 1, 1'b1, 0, NONE, NONE, NONE);
    exp_done++;
    chk("odd_bad_perr", 32'(bus.parity_err), 32'h1);
    bus.parity_odd = 1'b0;

    // reset during data bit 4 (its centre is tick 87 of the frame)
    send_frame(8'hFF, 1, 1'b0, 0, NONE, 84, NONE);
    @(negedge clk);
    bus.rx = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_dout", 32'(bus.dout), 32'h0);
    chk("midrst_perr", 32'(bus.parity_err), 32'h0);
    chk("midrst_ferr", 32'(bus.frame_err), 32'h0);
    chk("midrst_done", 32'(bus.rx_done_tick), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * OSR) do_tick();
    chk("midrst_nodone", 32'(done_cnt), 32'(exp_done));

    bus.parity_en = 1'b0;
    send_frame(8'h5A, 0, 1'b0, 0, NONE, NONE, NONE);
    exp_done++;
    chk("5a_done", 32'(done_cnt), 32'(exp_done));
    chk("5a_dout", 32'(bus.dout), 32'h5A);
    chk("5a_perr", 32'(bus.parity_err), 32'h0);
    chk("5a_ferr", 32'(bus.frame_err), 32'h0);

    send_frame(8'h3C, 0, 1'b0, 1, NONE, NONE, NONE);
    exp_done++;
    chk("ferr_done", 32'(done_cnt), 32'(exp_done));
    chk("ferr_dout", 32'(bus.dout), 32'h3C);
    chk("ferr_flag", 32'(bus.frame_err), 32'h1);
    chk("ferr_perr", 32'(bus.parity_err), 32'h0);

    bus.rx = 1'b0;
    repeat (3) do_tick();
    bus.rx = 1'b1;
    repeat (2 * OSR) do_tick();
    chk("glitch_nodone", 32'(done_cnt), 32'(exp_done));
    chk("glitch_dout", 32'(bus.dout), 32'h3C);
    chk("glitch_ferr", 32'(bus.frame_err), 32'h1);

    send_frame(8'h96, 0, 1'b0, 0, NONE, NONE, NONE);
    exp_done++;
    chk("recov_done", 32'(done_cnt), 32'(exp_done));
    chk("recov_dout", 32'(bus.dout), 32'h96);
    chk("recov_ferr", 32'(bus.frame_err), 32'h0);

    // parity_en flips mid-frame; this frame must still be taken as 8N1
    send_frame(8'hC3, 0, 1'b0, 0, NONE, NONE, 40);
    exp_done++;
    chk("flip_done", 32'(done_cnt), 32'(exp_done));
    chk("flip_dout", 32'(bus.dout), 32'hC3);
    chk("flip_perr", 32'(bus.parity_err), 32'h0);
    chk("flip_ferr", 32'(bus.frame_err), 32'h0);
    bus.parity_en = 1'b0;

    // one-tick high spike at the decision tick of data bit 0 (frame tick 23)
    send_frame(8'h00, 0, 1'b0, 0, 23, NONE, NONE);
    exp_done++;
    chk("maj_done", 32'(done_cnt), 32'(exp_done));
`ifdef UART_RX_MAJORITY_EN
    chk("maj_dout", 32'(bus.dout), 32'h00);
`else
    chk("maj_dout", 32'(bus.dout), 32'h01);
`endif

    chk("done_width", 32'(long_pulse), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
